// File: rtl/seg_display_reader.sv
// Reads two active-low seven-segment digits, debounces the 14-bit pattern and
// emits one {value, err} report per distinct stable reading over a valid/ready handshake.
//
//   state  | meaning
//   -------+-----------------------------------------------------------
//   SETTLE | sample changed recently, counter below STABLE_CYCLES
//   STABLE | sample unchanged for STABLE_CYCLES cycles, decode is final
module seg_display_reader #(
   parameter int STABLE_CYCLES = 16
) (
   input  logic       i_clk,
   input  logic       i_reset_n,
   input  logic [6:0] i_seg1,
   input  logic [6:0] i_seg2,
   input  logic       i_ready,
   output logic       o_valid,
   output logic [7:0] o_value,
   output logic       o_err
);

   localparam int CW = $clog2(STABLE_CYCLES + 1);
   localparam logic [CW-1:0] CNT_MAX = CW'(STABLE_CYCLES);
   localparam logic [CW-1:0] CNT_PRE = CW'(STABLE_CYCLES - 1);

   typedef enum logic {
      SETTLE = 1'b0,
      STABLE = 1'b1
   } state_t;

   logic [13:0]   sync1;
   logic [13:0]   sync2;
   logic [13:0]   sample_prev;
   logic [CW-1:0] cnt;
   state_t        state;

   logic [8:0]    store;
   logic          store_v;
   logic [8:0]    last;
   logic          last_v;

   logic          sample_chg;
   logic          cand_hit;
   logic          cand_new;
   logic          accept;
   logic [4:0]    dec_hi;
   logic [4:0]    dec_lo;
   logic [8:0]    cand;
   logic [8:0]    cur;

   // Returns {err, nibble}; unknown glyphs (including blank) give nibble 0 with err set.
   function automatic logic [4:0] decode_digit(input logic [6:0] seg_n);
      logic [6:0] seg;
      logic [4:0] res;
      seg = ~seg_n;
      res = 5'h10;
      case (seg)
         7'h3F: res = 5'h00;
         7'h06: res = 5'h01;
         7'h5B: res = 5'h02;
         7'h4F: res = 5'h03;
         7'h66: res = 5'h04;
         7'h6D: res = 5'h05;
         7'h7D: res = 5'h06;
         7'h07: res = 5'h07;
         7'h7F: res = 5'h08;
         7'h6F: res = 5'h09;
         7'h77: res = 5'h0A;
         7'h7C: res = 5'h0B;
         7'h39: res = 5'h0C;
         7'h5E: res = 5'h0D;
         7'h79: res = 5'h0E;
         7'h71: res = 5'h0F;
         default: res = 5'h10;
      endcase
      return res;
   endfunction

   assign dec_hi     = decode_digit(sync2[13:7]);
   assign dec_lo     = decode_digit(sync2[6:0]);
   assign cand       = {dec_hi[3:0], dec_lo[3:0], dec_hi[4] | dec_lo[4]};
   assign cur        = {o_value, o_err};
   assign accept     = o_valid & i_ready;
   assign sample_chg = (sync2 != sample_prev);

   // Fires on the edge at which the counter steps onto its terminal value.
   assign cand_hit   = (state == SETTLE) && !sample_chg && (cnt == CNT_PRE);
   assign cand_new   = cand_hit && (!last_v || (cand != last));

   always_ff @(posedge i_clk) begin
      if (!i_reset_n) begin
         sync1       <= '1;
         sync2       <= '1;
         sample_prev <= '1;
         cnt         <= '0;
         state       <= SETTLE;
         store       <= '0;
         store_v     <= 1'b0;
         last        <= '0;
         last_v      <= 1'b0;
         o_valid     <= 1'b0;
         o_value     <= 8'h00;
         o_err       <= 1'b0;
      end else begin
         sync1       <= {i_seg1, i_seg2};
         sync2       <= sync1;
         sample_prev <= sync2;

         if (sample_chg) begin
            cnt   <= '0;
            state <= SETTLE;
         end else if (cnt != CNT_MAX) begin
            cnt   <= cnt + 1'b1;
            state <= (cnt == CNT_PRE) ? STABLE : SETTLE;
         end

         if (accept) begin
            // Acceptance is retired first; anything queued is judged against it.
            o_valid <= 1'b0;
            last    <= cur;
            last_v  <= 1'b1;
            if (cand_hit) begin
               store   <= cand;
               store_v <= (cand != cur);
            end else begin
               store_v <= store_v && (store != cur);
            end
         end else if (o_valid) begin
            if (cand_new) begin
               store   <= cand;
               store_v <= 1'b1;
            end
         end else if (cand_new) begin
            o_valid <= 1'b1;
            o_value <= cand[8:1];
            o_err   <= cand[0];
            store_v <= 1'b0;
         end else if (store_v) begin
            o_valid <= 1'b1;
            o_value <= store[8:1];
            o_err   <= store[0];
            store_v <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_seg_display_reader.sv
// Directed bench for seg_display_reader with STABLE_CYCLES=4; expected values are hand-derived.
module tb_seg_display_reader;

   localparam int SC = 4;

   logic       i_clk = 1'b0;
   logic       i_reset_n;
   logic [6:0] i_seg1;
   logic [6:0] i_seg2;
   logic       i_ready;
   logic       o_valid;
   logic [7:0] o_value;
   logic       o_err;

   int tests_run    = 0;
   int tests_failed = 0;
   int b6_seen      = 0;

   always #5 i_clk = ~i_clk;

   seg_display_reader #(.STABLE_CYCLES(SC)) dut (
      .i_clk     (i_clk),
      .i_reset_n (i_reset_n),
      .i_seg1    (i_seg1),
      .i_seg2    (i_seg2),
      .i_ready   (i_ready),
      .o_valid   (o_valid),
      .o_value   (o_value),
      .o_err     (o_err)
   );

   always @(negedge i_clk)
      if (o_valid && o_value == 8'hB6) b6_seen <= b6_seen + 1;

   function automatic logic [6:0] seg_n(input logic [3:0] d);
      logic [6:0] g;
      case (d)
         4'h0: g = 7'h3F;  4'h1: g = 7'h06;  4'h2: g = 7'h5B;  4'h3: g = 7'h4F;
         4'h4: g = 7'h66;  4'h5: g = 7'h6D;  4'h6: g = 7'h7D;  4'h7: g = 7'h07;
         4'h8: g = 7'h7F;  4'h9: g = 7'h6F;  4'hA: g = 7'h77;  4'hB: g = 7'h7C;
         4'hC: g = 7'h39;  4'hD: g = 7'h5E;  4'hE: g = 7'h79;  default: g = 7'h71;
      endcase
      return ~g;
   endfunction

   task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
      tests_run++;
      if (got !== exp) begin
         tests_failed++;
         $display("FAIL %s: got %0h expected %0h", tag, got, exp);
      end
   endtask

   task automatic tick();
      @(posedge i_clk);
      #1;
   endtask

   task automatic drive(input logic [3:0] hi, input logic [3:0] lo);
      i_seg1 = seg_n(hi);
      i_seg2 = seg_n(lo);
   endtask

   // Edges until o_valid is seen; 999 if it never rises within max edges.
   task automatic wait_valid(input int max, output int n);
      n = 0;
      while (n < max) begin
         tick();
         n++;
         if (o_valid) break;
      end
      if (!o_valid) n = 999;
   endtask

   task automatic count_valid(input int cycles, output int c);
      c = 0;
      for (int i = 0; i < cycles; i++) begin
         tick();
         if (o_valid) c++;
      end
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      int n;
      int c;
      int c2;
      int v;

      i_reset_n = 1'b0;
      i_ready   = 1'b1;
      i_seg1    = ~7'h66;
      i_seg2    = ~7'h5B;
      repeat (3) tick();
      check_eq("rst_valid", o_valid, 0);
      check_eq("rst_value", o_value, 8'h00);
      check_eq("rst_err", o_err, 0);

      // first report after release: "42"
      i_reset_n = 1'b1;
      wait_valid(20, n);
      check_eq("r42_latency", n, 7);
      check_eq("r42_value", o_value, 8'h42);
      check_eq("r42_err", o_err, 0);
      tick();
      check_eq("r42_pulse", o_valid, 0);

      // toggling input never settles, then "17" holds
      v = 0;
      for (int i = 0; i < 10; i++) begin
         if (i % 2 == 0) drive(4'h1, 4'h1);
         else            drive(4'h7, 4'h7);
         count_valid(2, c);
         v += c;
      end
      check_eq("toggle_quiet", v, 0);
      drive(4'h1, 4'h7);
      wait_valid(20, n);
      check_eq("r17_latency", n, 7);
      check_eq("r17_value", o_value, 8'h17);
      tick();

      // upper digit "8" with segment c missing
      i_seg1 = ~7'h7B;
      i_seg2 = seg_n(4'h1);
      wait_valid(20, n);
      check_eq("bad_latency", n, 7);
      check_eq("bad_err", o_err, 1);
      check_eq("bad_value", o_value, 8'h01);
      tick();

      // back-pressure: A5 held, B6 overwritten by C7
      i_ready = 1'b0;
      drive(4'hA, 4'h5);
      wait_valid(20, n);
      check_eq("a5_value", o_value, 8'hA5);
      drive(4'hB, 4'h6);
      count_valid(10, c);
      check_eq("hold_b6_valid", c, 10);
      check_eq("hold_b6_value", o_value, 8'hA5);
      drive(4'hC, 4'h7);
      count_valid(10, c);
      check_eq("hold_c7_valid", c, 10);
      check_eq("hold_c7_value", o_value, 8'hA5);
      check_eq("hold_c7_err", o_err, 0);
      i_ready = 1'b1;
      tick();
      check_eq("a5_accept_gap", o_valid, 0);
      tick();
      check_eq("c7_valid", o_valid, 1);
      check_eq("c7_value", o_value, 8'hC7);
      tick();
      check_eq("c7_accept", o_valid, 0);
      count_valid(12, c);
      check_eq("after_c7_quiet", c, 0);

      // 33 accepted, glitch to 38 for two cycles, back to 33
      drive(4'h3, 4'h3);
      wait_valid(20, n);
      check_eq("r33_latency", n, 7);
      check_eq("r33_value", o_value, 8'h33);
      tick();
      drive(4'h3, 4'h8);
      count_valid(2, c);
      drive(4'h3, 4'h3);
      count_valid(20, c2);
      check_eq("glitch_quiet", c + c2, 0);

      // reset while FF is pending
      i_ready = 1'b0;
      drive(4'hF, 4'hF);
      wait_valid(20, n);
      check_eq("ff_value", o_value, 8'hFF);
      i_reset_n = 1'b0;
      tick();
      check_eq("midrst_valid", o_valid, 0);
      check_eq("midrst_value", o_value, 8'h00);
      i_reset_n = 1'b1;
      wait_valid(20, n);
      check_eq("ff_again_latency", n, 7);
      check_eq("ff_again_value", o_value, 8'hFF);
      check_eq("ff_again_err", o_err, 0);
      i_ready = 1'b1;
      tick();

      // blank display decodes as error
      i_seg1 = 7'h7F;
      i_seg2 = 7'h7F;
      wait_valid(20, n);
      check_eq("blank_latency", n, 7);
      check_eq("blank_value", o_value, 8'h00);
      check_eq("blank_err", o_err, 1);
      tick();

      drive(4'hE, 4'hD);
      wait_valid(20, n);
      check_eq("ed_value", o_value, 8'hED);
      check_eq("ed_err", o_err, 0);
      tick();

      check_eq("b6_never", b6_seen, 0);

      $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
      $finish;
   end

endmodule

// File: doc/seg_display_reader.md
SEG_DISPLAY_READER -- requirements
Module: seg_display_reader

Interface
REQ-001 SHALL have parameter STABLE_CYCLES, default 16, the number of consecutive unchanged synchronized samples needed before a pattern is decoded (legal range 2..65535).
REQ-002 SHALL have port i_clk, input, 1, the single clock; all logic on its rising edge.
REQ-003 SHALL have port i_reset_n, input, 1, the reset; reset is synchronous and active-low.
REQ-004 SHALL have port i_seg1, input, 7, active-low segments of the upper digit, bit order {g,f,e,d,c,b,a}.
REQ-005 SHALL have port i_seg2, input, 7, active-low segments of the lower digit, same order.
REQ-006 SHALL have port i_ready, input, 1, consumer accepts o_value/o_err while o_valid=1.
REQ-007 SHALL have port o_valid, output, 1, a decoded report is pending.
REQ-008 SHALL have port o_value, output, 8, decoded byte {upper nibble, lower nibble}.
REQ-009 SHALL have port o_err, output, 1, at least one digit pattern is not a legal hex glyph.

Function
REQ-010 SHALL pass all 14 segment inputs through a 2-flop synchronizer before any other use.
REQ-011 SHALL invert the synchronized lines to active-high and decode each digit against this table (gfedcba hex): 0=3F 1=06 2=5B 3=4F 4=66 5=6D 6=7D 7=07 8=7F 9=6F A=77 b=7C C=39 d=5E E=79 F=71.
REQ-012 SHALL decode any other pattern, including all-segments-off, as nibble 0 and set the error flag for that report.
REQ-013 SHALL keep a stability counter with width ceil(log2(STABLE_CYCLES+1)); it clears to 0 on any cycle where the synchronized 14-bit sample differs from the previous cycle's sample, otherwise increments and saturates at STABLE_CYCLES.
REQ-014 SHALL use states SETTLE (counter < STABLE_CYCLES) and STABLE (counter = STABLE_CYCLES); any sample change returns to SETTLE on that same edge.
REQ-015 SHALL, on the cycle the counter first reaches STABLE_CYCLES, compare the decoded {value, err} with the last reported {value, err}; if different, or if nothing has been reported since reset, it becomes a new report candidate.
REQ-016 SHALL, with no report pending, load the candidate into o_value/o_err and set o_valid on the next edge; total latency from the first edge that samples a new constant input to o_valid=1 is STABLE_CYCLES+3 edges.
REQ-017 SHALL hold o_valid, o_value and o_err constant while o_valid=1 and i_ready=0.
REQ-018 SHALL clear o_valid on the edge where o_valid=1 and i_ready=1, and record {o_value, o_err} as last reported.
REQ-019 SHALL, while a report is pending, store only the most recent candidate (one-deep, overwrite); on acceptance, the stored candidate is presented on the following edge only if it differs from the just-accepted report, otherwise it is dropped.
REQ-020 SHALL not issue a report for a pattern that reverts to the last reported value before reaching STABLE_CYCLES.
REQ-021 SHALL treat simultaneous acceptance and new candidate as: accept first, then compare the candidate against the newly accepted report.
REQ-022 SHALL keep o_valid low for at least one cycle between consecutive reports.

Reset
REQ-023 SHALL, while i_reset_n=0 at a rising edge, set o_valid=0, o_value=8'h00, o_err=0, synchronizer flops to all-ones (segments off), counter 0, state SETTLE, stored candidate empty, last-reported marked none.
REQ-024 SHALL discard any pending or stored report on reset asserted mid-operation; the first stable pattern after release is always reported.

Verification (STABLE_CYCLES=4)
REQ-025 Reset release, inputs steady at patterns for "4" and "2" (active-low ~66, ~5B), i_ready=1 -> o_valid pulses one cycle 7 edges after release, o_value=8'h42, o_err=0.
REQ-026 Inputs toggle between "1" and "7" every 2 cycles for 20 cycles, then hold "17" -> no o_valid during toggling; single report 8'h17 exactly 7 edges after the last change.
REQ-027 Upper digit pattern 0x7F with segment c stuck off (0x7B) -> o_valid with o_err=1, o_value upper nibble 0.
REQ-028 i_ready=0, stable "A5" reported, then input changes to "B6" then "C7" (each stable) -> o_value holds 8'hA5; after i_ready=1 for one edge, next report is 8'hC7 only; "B6" never appears.
REQ-029 Report 8'h33 accepted; input glitches to "38" for 2 cycles and returns to "33" -> no further o_valid.
REQ-030 i_reset_n low for 1 cycle while o_valid=1 with 8'hFF -> next edge o_valid=0, o_value=8'h00; after release, 8'hFF is reported again after 7 edges.
